// File: rtl/dedekind_core_pkg.sv
// Shared widths and error flag positions for the count-connected
// core cluster.
package dedekind_core_pkg;
    localparam int COUNT_W    = 6;
    localparam int GRAPH_W    = 128;
    localparam int INFLIGHT_W = 16;
    localparam int ERR_W      = 3;

    localparam int ERR_COLLISION = 0;
    localparam int ERR_FORCED    = 1;
    localparam int ERR_UNDERFLOW = 2;

    localparam logic [INFLIGHT_W-1:0] INFLIGHT_MAX = '1;
endpackage

// File: rtl/rr_free_select.sv
// Round-robin picker: first entry at or after ptr (wrapping) whose
// busy bit is clear.
module rr_free_select #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     busy,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);
    int j;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!found && !busy[j]) begin
                idx   = IDX_W'(j);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/count_connected_dispatcher.sv
// Fans one bot stream out to N_CORES count-connected cores and merges
// their in-order result streams back into one.
module count_connected_dispatcher
    import dedekind_core_pkg::*;
#(
    parameter int N_CORES          = 4,
    parameter int EXTRA_DATA_WIDTH = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 isBotValid,
    input  logic [GRAPH_W-1:0]                   graphIn,
    input  logic [EXTRA_DATA_WIDTH-1:0]          extraDataIn,
    output logic                                 slowDownInput,
    output logic [N_CORES-1:0]                   coreBotValid,
    output logic [GRAPH_W-1:0]                   coreGraph,
    output logic [EXTRA_DATA_WIDTH-1:0]          coreExtraData,
    input  logic [N_CORES-1:0]                   coreSlowDown,
    input  logic [N_CORES-1:0]                   coreResultValid,
    input  logic [COUNT_W*N_CORES-1:0]           coreConnectCount,
    input  logic [EXTRA_DATA_WIDTH*N_CORES-1:0]  coreExtraDataOut,
    input  logic [N_CORES-1:0]                   coreEcc,
    input  logic [2*N_CORES-1:0]                 coreActivity,
    output logic                                 resultValid,
    output logic [COUNT_W-1:0]                   connectCount,
    output logic [EXTRA_DATA_WIDTH-1:0]          extraDataOut,
    output logic                                 eccStatus,
    output logic [$clog2(2*N_CORES+1)-1:0]       activitySum,
    output logic [INFLIGHT_W-1:0]                inFlight,
    output logic [ERR_W-1:0]                     errorFlags
);
    localparam int IDX_W = $clog2(N_CORES);
    localparam int ACT_W = $clog2(2*N_CORES+1);

    logic [IDX_W-1:0] rrPtr;
    logic [IDX_W-1:0] freeIdx;
    logic [IDX_W-1:0] selIdx;
    logic [IDX_W-1:0] nextPtr;
    logic             freeFound;

    rr_free_select #(
        .N     (N_CORES),
        .IDX_W (IDX_W)
    ) uSelect (
        .busy  (coreSlowDown),
        .ptr   (rrPtr),
        .idx   (freeIdx),
        .found (freeFound)
    );

    // With every core throttled we still push to rrPtr; the core FIFOs
    // keep enough slack for the bots already on their way.
    assign selIdx  = freeFound ? freeIdx : rrPtr;
    assign nextPtr = (selIdx == IDX_W'(N_CORES-1)) ? '0 : selIdx + 1'b1;

    logic [COUNT_W-1:0]          mergeCount;
    logic [EXTRA_DATA_WIDTH-1:0] mergeExtra;
    logic                        mergeHit;
    logic [ACT_W-1:0]            actSum;
    logic                        dispatched;
    logic                        returned;

    always_comb begin
        mergeCount = '0;
        mergeExtra = '0;
        mergeHit   = 1'b0;
        for (int k = 0; k < N_CORES; k++) begin
            if (coreResultValid[k] && !mergeHit) begin
                mergeCount = coreConnectCount[COUNT_W*k +: COUNT_W];
                mergeExtra = coreExtraDataOut[EXTRA_DATA_WIDTH*k +: EXTRA_DATA_WIDTH];
                mergeHit   = 1'b1;
            end
        end
    end

    always_comb begin
        actSum = '0;
        for (int k = 0; k < N_CORES; k++) begin
            actSum = actSum + ACT_W'(coreActivity[2*k +: 2]);
        end
    end

    assign dispatched = |coreBotValid;
    assign returned   = |coreResultValid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrPtr         <= '0;
            coreBotValid  <= '0;
            coreGraph     <= '0;
            coreExtraData <= '0;
            slowDownInput <= 1'b0;
        end else begin
            slowDownInput <= &coreSlowDown;
            coreBotValid  <= '0;
            if (isBotValid) begin
                coreBotValid  <= N_CORES'(1) << selIdx;
                coreGraph     <= graphIn;
                coreExtraData <= extraDataIn;
                rrPtr         <= nextPtr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resultValid  <= 1'b0;
            connectCount <= '0;
            extraDataOut <= '0;
            eccStatus    <= 1'b0;
            activitySum  <= '0;
        end else begin
            resultValid <= mergeHit;
            eccStatus   <= |coreEcc;
            activitySum <= actSum;
            if (mergeHit) begin
                connectCount <= mergeCount;
                extraDataOut <= mergeExtra;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inFlight   <= '0;
            errorFlags <= '0;
        end else begin
            if ($countones(coreResultValid) > 1)
                errorFlags[ERR_COLLISION] <= 1'b1;
            if (isBotValid && !freeFound)
                errorFlags[ERR_FORCED] <= 1'b1;
            if (dispatched && !returned) begin
                if (inFlight != INFLIGHT_MAX)
                    inFlight <= inFlight + 1'b1;
            end else if (!dispatched && returned) begin
                if (inFlight == '0)
                    errorFlags[ERR_UNDERFLOW] <= 1'b1;
                else
                    inFlight <= inFlight - 1'b1;
            end
        end
    end
endmodule

// File: doc/count_connected_dispatcher.md
Name: count_connected_dispatcher

Overview:
- Shares one upstream bot stream between N_CORES streaming count-connected cores.
- Each valid bot goes to one core, picked round-robin among the cores that are not throttled. Graph and extra data are broadcast to all cores.
- Each core returns results in input order after a fixed latency, and at most one core receives a bot per cycle. The dispatcher therefore merges the core result streams into one output stream without reordering.
- It also aggregates ECC, activity and in-flight accounting.

Parameters:
- N_CORES, 4, number of cores served (2..16).
- EXTRA_DATA_WIDTH, 1, width of per-bot sideband data.
- IDX_W, $clog2(N_CORES), core index width (derived, localparam).
- ACT_W, $clog2(2*N_CORES+1), activity sum width (derived, localparam).

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- isBotValid  in  1  upstream bot valid.
- graphIn  in  128  upstream graph.
- extraDataIn  in  EXTRA_DATA_WIDTH  upstream sideband.
- slowDownInput  out  1  throttle to upstream.
- coreBotValid  out  N_CORES  per-core write strobe, one-hot or zero.
- coreGraph  out  128  broadcast graph.
- coreExtraData  out  EXTRA_DATA_WIDTH  broadcast sideband.
- coreSlowDown  in  N_CORES  per-core almost-full.
- coreResultValid  in  N_CORES  per-core result valid.
- coreConnectCount  in  6*N_CORES  packed counts; core k at [6k+5:6k].
- coreExtraDataOut  in  EXTRA_DATA_WIDTH*N_CORES  packed sideband.
- coreEcc  in  N_CORES  per-core ECC status.
- coreActivity  in  2*N_CORES  packed 0..2 activity.
- resultValid  out  1  merged result valid.
- connectCount  out  6  merged count.
- extraDataOut  out  EXTRA_DATA_WIDTH  merged sideband.
- eccStatus  out  1  OR of coreEcc, registered.
- activitySum  out  ACT_W  sum of coreActivity, registered.
- inFlight  out  16  bots dispatched minus results returned.
- errorFlags  out  3  sticky: [0] collision, [1] forced dispatch, [2] inFlight underflow.

Behaviour:
- Reset, asynchronous: all outputs, pointer, counters and flags go to 0. Reset mid-operation discards any in-flight accounting. coreBotValid is 0 on the first edge after release.
- Dispatch, latency 1:
  - Valid cycle: coreGraph, coreExtraData and coreBotValid are registered from the inputs.
  - Invalid cycle: coreBotValid is 0 and the broadcast data holds its previous value.
  - Selection: the first core k, scanning from rrPtr upward modulo N_CORES, with coreSlowDown[k]=0. Sample coreSlowDown in the same cycle as isBotValid.
  - After a valid dispatch: rrPtr <= k+1 mod N_CORES. rrPtr holds otherwise.
  - All cores throttled while valid: dispatch to rrPtr anyway (core FIFO margin absorbs it), set errorFlags[1], advance rrPtr.
- slowDownInput: registered AND of coreSlowDown. It is 1 only when every core is throttled.
- Merge, latency 1:
  - resultValid <= |coreResultValid.
  - connectCount and extraDataOut come from the lowest-index valid core. They hold their previous value when no core is valid.
  - Popcount of coreResultValid > 1: set errorFlags[0]; still output the lowest index.
- inFlight, updated each cycle from the registered dispatch strobe and the merge input valid:
  - dispatch only: +1.
  - result only: -1.
  - both in the same cycle: unchanged.
  - result while inFlight=0: stay 0 and set errorFlags[2].
  - at 0xFFFF: saturate.
- eccStatus and activitySum are combinational reductions of the core inputs, registered once. They are not sticky.
- errorFlags clear only on rst.

Decomposition:
- Shared package `dedekind_core_pkg`: COUNT_W=6, GRAPH_W=128, INFLIGHT_W=16, errorFlags bit indices.
- One sub-module `rr_free_select`: combinational round-robin first-free picker (mask, pointer -> index, found). Dispatcher and merge logic stay in the top.

Test Plan:
- N=4, all cores free, 8 consecutive valid bots -> coreBotValid cycles 0001, 0010, 0100, 1000, 0001… each one cycle after input; inFlight reaches 8.
- coreSlowDown=0010, rrPtr=1, one valid bot -> dispatch to core 2 (0100); rrPtr becomes 3.
- coreSlowDown=1111 -> slowDownInput=1 next cycle. A bot still arriving goes to rrPtr and sets errorFlags=010. slowDownInput drops one cycle after any core frees.
- coreResultValid=0100, count 6'd37, extra 1 -> next cycle resultValid=1, connectCount=37, extraDataOut=1, inFlight decremented.
- coreResultValid=0110 -> output core 1 data, errorFlags[0]=1; it stays set until rst. A result at inFlight=0 sets errorFlags[2].
- rst asserted mid-stream, asynchronously -> coreBotValid, resultValid, inFlight and errorFlags are 0 immediately; the first bot after release goes to core 0.
